// File: rtl/bus_sequencer.sv
// Four-phase bus master for a small register file: fetch, load operand, add immediate, store.
// Owns the program counter and carry flag; every bus strobe and STOREBUS is a flop output.
module bus_sequencer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [DATA_W+3:0] INSTR,
  input  logic [DATA_W-1:0] LOADBUS,
  output logic [DATA_W-1:0] STOREBUS,
  output logic              nA_OUT,
  output logic              nB_OUT,
  output logic              nIN_OUT,
  output logic              nA_ST,
  output logic              nB_ST,
  output logic              nOUT_ST,
  output logic [PC_W-1:0]   PC,
  output logic              CF,
  output logic [1:0]        PHASE
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SUM_W = DATA_W + 1;

  typedef enum logic [1:0] {FETCH = 2'd0, LOAD = 2'd1, EXEC = 2'd2, STORE = 2'd3} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_IN} src_t;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_B, DST_OUT} dst_t;

  state_t              r_state;
  logic [DATA_W+3:0]   r_ir;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_storebus;
  logic                r_cnext;
  logic                r_cf;
  logic [PC_W-1:0]     r_pc;
  logic                r_na_out, r_nb_out, r_nin_out;
  logic                r_na_st, r_nb_st, r_nout_st;

  logic [OP_W-1:0]     w_fetch_op;
  logic [OP_W-1:0]     w_ir_op;
  logic [SUM_W-1:0]    w_sum;
  logic                w_jump;

  function automatic src_t f_src(input logic [OP_W-1:0] op);
    case (op)
      4'h0, 4'h4:        f_src = SRC_A;
      4'h1, 4'h5, 4'h9:  f_src = SRC_B;
      4'h2, 4'h6:        f_src = SRC_IN;
      default:           f_src = SRC_NONE;
    endcase
  endfunction

  function automatic dst_t f_dst(input logic [OP_W-1:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: f_dst = DST_A;
      4'h4, 4'h5, 4'h6, 4'h7: f_dst = DST_B;
      4'h9, 4'hB:             f_dst = DST_OUT;
      default:                f_dst = DST_NONE;
    endcase
  endfunction

  assign w_fetch_op = INSTR[DATA_W+3:DATA_W];
  assign w_ir_op    = r_ir[DATA_W+3:DATA_W];
  assign w_sum      = SUM_W'(r_operand) + SUM_W'(r_ir[DATA_W-1:0]);
  // JNC looks at the carry left by the previous instruction, before this one rewrites it
  assign w_jump     = (w_ir_op == 4'hF) || ((w_ir_op == 4'hE) && !r_cf);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= FETCH;
      r_ir       <= '0;
      r_operand  <= '0;
      r_storebus <= '0;
      r_cnext    <= 1'b0;
      r_cf       <= 1'b0;
      r_pc       <= '0;
      r_na_out   <= 1'b1;
      r_nb_out   <= 1'b1;
      r_nin_out  <= 1'b1;
      r_na_st    <= 1'b1;
      r_nb_st    <= 1'b1;
      r_nout_st  <= 1'b1;
    end else begin
      case (r_state)
        FETCH: begin
          if (RUN) begin
            r_ir      <= INSTR;
            r_state   <= LOAD;
            r_na_out  <= (f_src(w_fetch_op) != SRC_A);
            r_nb_out  <= (f_src(w_fetch_op) != SRC_B);
            r_nin_out <= (f_src(w_fetch_op) != SRC_IN);
          end
        end
        LOAD: begin
          r_operand <= (f_src(w_ir_op) == SRC_NONE) ? '0 : LOADBUS;
          r_na_out  <= 1'b1;
          r_nb_out  <= 1'b1;
          r_nin_out <= 1'b1;
          r_state   <= EXEC;
        end
        EXEC: begin
          r_storebus <= w_sum[DATA_W-1:0];
          r_cnext    <= w_sum[DATA_W];
          r_na_st    <= (f_dst(w_ir_op) != DST_A);
          r_nb_st    <= (f_dst(w_ir_op) != DST_B);
          r_nout_st  <= (f_dst(w_ir_op) != DST_OUT);
          r_state    <= STORE;
        end
        STORE: begin
          r_na_st   <= 1'b1;
          r_nb_st   <= 1'b1;
          r_nout_st <= 1'b1;
          r_cf      <= r_cnext;
          r_pc      <= w_jump ? PC_W'(r_storebus) : r_pc + PC_W'(1);
          r_state   <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign STOREBUS = r_storebus;
  assign nA_OUT   = r_na_out;
  assign nB_OUT   = r_nb_out;
  assign nIN_OUT  = r_nin_out;
  assign nA_ST    = r_na_st;
  assign nB_ST    = r_nb_st;
  assign nOUT_ST  = r_nout_st;
  assign PC       = r_pc;
  assign CF       = r_cf;
  assign PHASE    = r_state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed and random instruction stream for bus_sequencer, with a queue of expected
// per-instruction results produced by a behavioural model of the opcode table.
module tb_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RUN;
  logic [7:0] INSTR;
  logic [3:0] LOADBUS;
  logic [3:0] STOREBUS;
  logic       nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST;
  logic [3:0] PC;
  logic       CF;
  logic [1:0] PHASE;

  bus_sequencer #(.DATA_W(4), .PC_W(4)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .LOADBUS(LOADBUS),
    .STOREBUS(STOREBUS), .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST), .PC(PC), .CF(CF), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] sb;
    logic [3:0] pc;
    logic       cf;
    logic [2:0] st;
  } exp_t;

  exp_t       sbq[$];
  int         nerr = 0;
  int         nchk = 0;
  logic [3:0] m_pc;
  logic       m_cf;

  wire [2:0] outs = {nIN_OUT, nB_OUT, nA_OUT};
  wire [2:0] sts  = {nOUT_ST, nB_ST, nA_ST};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Active-low {IN,B,A} source enables expected in LOAD
  function automatic logic [2:0] src_mask(input logic [3:0] op);
    case (op)
      4'h0, 4'h4:       return 3'b110;
      4'h1, 4'h5, 4'h9: return 3'b101;
      4'h2, 4'h6:       return 3'b011;
      default:          return 3'b111;
    endcase
  endfunction

  // Active-low {OUT,B,A} store strobes expected in STORE
  function automatic logic [2:0] dst_mask(input logic [3:0] op);
    if (op <= 4'h3)                 return 3'b110;
    if (op <= 4'h7)                 return 3'b101;
    if (op == 4'h9 || op == 4'hB)   return 3'b011;
    return 3'b111;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b0; RUN = 1'b0; INSTR = '0; LOADBUS = '0;
    tick; tick;
    RST = 1'b1;
    m_pc = '0;
    m_cf = 1'b0;
    tick;
  endtask

  task automatic run_instr(input string tag, input logic [7:0] instr, input logic [3:0] lb);
    logic [3:0] op, imm, operand;
    logic [4:0] sum5;
    exp_t e;
    op      = instr[7:4];
    imm     = instr[3:0];
    operand = (src_mask(op) != 3'b111) ? lb : 4'h0;
    sum5    = {1'b0, operand} + {1'b0, imm};
    e.sb    = sum5[3:0];
    e.cf    = sum5[4];
    e.st    = dst_mask(op);
    e.pc    = (op == 4'hF || (op == 4'hE && !m_cf)) ? sum5[3:0] : m_pc + 4'd1;
    m_pc    = e.pc;
    m_cf    = e.cf;
    sbq.push_back(e);

    RUN = 1'b1; INSTR = instr; LOADBUS = lb;
    tick;
    RUN = 1'b0;
    INSTR = 8'($urandom);
    chk({tag, "/load_phase"}, 32'(PHASE), 32'd1);
    chk({tag, "/load_outs"}, 32'(outs), 32'(src_mask(op)));
    chk({tag, "/load_sts"}, 32'(sts), 32'h7);
    tick;
    LOADBUS = ~lb;
    chk({tag, "/exec_phase"}, 32'(PHASE), 32'd2);
    chk({tag, "/exec_strobes"}, 32'({outs, sts}), 32'h3f);
    tick;
    chk({tag, "/store_phase"}, 32'(PHASE), 32'd3);
    if (sbq.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "/store_bus"}, 32'(STOREBUS), 32'(e.sb));
      chk({tag, "/store_sts"}, 32'(sts), 32'(e.st));
      chk({tag, "/store_outs"}, 32'(outs), 32'h7);
      tick;
      chk({tag, "/fetch_phase"}, 32'(PHASE), 32'd0);
      chk({tag, "/fetch_strobes"}, 32'({outs, sts}), 32'h3f);
      chk({tag, "/pc"}, 32'(PC), 32'(e.pc));
      chk({tag, "/cf"}, 32'(CF), 32'(e.cf));
      chk({tag, "/bus_hold"}, 32'(STOREBUS), 32'(e.sb));
    end
  endtask

  initial begin
    RST = 1'b0; RUN = 1'b0; INSTR = '0; LOADBUS = '0;
    tick; tick;
    chk("rst/phase", 32'(PHASE), 32'd0);
    chk("rst/strobes", 32'({outs, sts}), 32'h3f);
    chk("rst/bus", 32'(STOREBUS), 32'd0);
    chk("rst/pc", 32'(PC), 32'd0);
    chk("rst/cf", 32'(CF), 32'd0);
    RST = 1'b1; m_pc = '0; m_cf = 1'b0;
    tick;

    // Reset landing in the middle of STORE of MOV A,5
    RUN = 1'b1; INSTR = 8'h35;
    tick; RUN = 1'b0;
    tick; tick;
    chk("t1/na_st_low", 32'(nA_ST), 32'd0);
    #2 RST = 1'b0;
    #1;
    chk("t1/na_st_rise", 32'(nA_ST), 32'd1);
    chk("t1/pc", 32'(PC), 32'd0);
    chk("t1/cf", 32'(CF), 32'd0);
    chk("t1/phase", 32'(PHASE), 32'd0);
    chk("t1/bus", 32'(STOREBUS), 32'd0);
    #1 RST = 1'b1;
    m_pc = '0; m_cf = 1'b0;
    tick;

    run_instr("t2_mov_a5", 8'h35, 4'h0);

    do_reset;
    run_instr("t3_add_a3", 8'h03, 4'hE);
    run_instr("t3_jnc_nt", 8'hE7, 4'h0);
    chk("t3/pc2", 32'(PC), 32'd2);
    run_instr("t3_jnc_tk", 8'hE7, 4'h0);
    chk("t3/pc7", 32'(PC), 32'd7);

    run_instr("t4_mov_ba", 8'h40, 4'h9);

    run_instr("t5_jmp15", 8'hFF, 4'h0);
    run_instr("t5_nop", 8'h80, 4'h0);
    chk("t5/pc_wrap", 32'(PC), 32'd0);
    run_instr("t5_jmp12", 8'hFC, 4'h0);
    chk("t5/pc12", 32'(PC), 32'd12);

    // Idle in FETCH while RUN is low
    for (int i = 0; i < 5; i++) begin
      INSTR = 8'($urandom);
      tick;
      chk("t6/idle_phase", 32'(PHASE), 32'd0);
      chk("t6/idle_strobes", 32'({outs, sts}), 32'h3f);
      chk("t6/idle_pc", 32'(PC), 32'd12);
    end
    run_instr("t6_resume", 8'h62, 4'hB);
    run_instr("t6_out_b", 8'h91, 4'h7);
    run_instr("t6_out_im", 8'hB6, 4'h3);

    for (int i = 0; i < 24; i++) begin
      run_instr("rand", 8'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
